hmac_job_master: RTL and testbench

- Register-bus initiator that drives one complete HMAC-SHA256 job into the hmac register map.
- Sequence: loads the key and the 512-bit message block, pulses start, polls the valid flag, reads back the 256-bit digest, and compares it with an expected digest.
- Sits between a secure-boot/attestation controller and the register-side bus of the HMAC peripheral, replacing software-driven MMIO sequences.

---
 rtl/hmac_job_master.sv | 229 ++++++++++++++++++++++
 tb/tb_hmac_job_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_job_master.sv
// Register-bus initiator that runs one HMAC-SHA256 job: loads key and message,
// starts the core, polls for valid, reads back the digest and checks it.
module hmac_job_master #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [511:0]          key_i,
  input  logic [511:0]          msg_i,
  input  logic [255:0]          expected_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  match_o,
  output logic                  timeout_o,
  output logic [255:0]          hash_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [63:0]           wdata_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [63:0]           rdata_i
);

  localparam int unsigned PW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_KEY, WR_MSG, WR_GO, WR_CLR, POLL, GAP, RD_HASH, FINISH
  } state_e;

  state_e                  state_q;
  logic [2:0]              cnt_q;
  logic [PW-1:0]           poll_q;
  logic [GW-1:0]           gap_q;
  logic [511:0]            key_q;
  logic [511:0]            msg_q;
  logic [255:0]            exp_q;
  logic [255:0]            hash_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    match_q;
  logic                    timeout_q;
  logic                    req_q;
  logic                    we_q;
  logic                    rwait_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [63:0]             wdata_q;
  logic                    xfer_done_s;
  logic                    poll_last_s;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [5:0] idx);
    reg_addr = BASE_ADDR + ADDR_WIDTH'({idx, 3'b000});
  endfunction

  function automatic logic [63:0] word_of(input logic [511:0] v, input logic [2:0] i);
    word_of = v[{i, 6'd0} +: 64];
  endfunction

  // A read may finish on the grant itself or on a later rvalid.
  assign xfer_done_s = (req_q && gnt_i && (we_q || rvalid_i)) || (rwait_q && rvalid_i);
  assign poll_last_s = (poll_q == PW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      poll_q    <= '0;
      gap_q     <= '0;
      key_q     <= 512'd0;
      msg_q     <= 512'd0;
      exp_q     <= 256'd0;
      hash_q    <= 256'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      rwait_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 64'd0;
    end else begin
      done_q <= 1'b0;
      if (req_q && gnt_i && !xfer_done_s) begin
        req_q   <= 1'b0;
        rwait_q <= 1'b1;
      end
      if (xfer_done_s) begin
        req_q   <= 1'b0;
        rwait_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            key_q     <= key_i;
            msg_q     <= msg_i;
            exp_q     <= expected_i;
            busy_q    <= 1'b1;
            cnt_q     <= 3'd0;
            poll_q    <= '0;
            gap_q     <= '0;
            hash_q    <= 256'd0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= WR_KEY;
          end
        end
        WR_KEY: begin
          if (!req_q && !rwait_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= reg_addr(6'd34 + {3'd0, cnt_q});
            wdata_q <= word_of(key_q, cnt_q);
          end else if (xfer_done_s) begin
            req_q <= 1'b1;
            if (cnt_q == 3'd7) begin
              state_q <= WR_MSG;
              cnt_q   <= 3'd0;
              addr_q  <= reg_addr(6'd1);
              wdata_q <= word_of(msg_q, 3'd0);
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              addr_q  <= reg_addr(6'd35 + {3'd0, cnt_q});
              wdata_q <= word_of(key_q, cnt_q + 3'd1);
            end
          end
        end
        WR_MSG: begin
          if (xfer_done_s) begin
            req_q <= 1'b1;
            if (cnt_q == 3'd7) begin
              state_q <= WR_GO;
              cnt_q   <= 3'd0;
              addr_q  <= reg_addr(6'd0);
              wdata_q <= 64'h1;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              addr_q  <= reg_addr(6'd2 + {3'd0, cnt_q});
              wdata_q <= word_of(msg_q, cnt_q + 3'd1);
            end
          end
        end
        WR_GO: begin
          if (xfer_done_s) begin
            state_q <= WR_CLR;
            req_q   <= 1'b1;
            addr_q  <= reg_addr(6'd0);
            wdata_q <= 64'h0;
          end
        end
        WR_CLR: begin
          if (xfer_done_s) begin
            state_q <= POLL;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= reg_addr(6'd17);
            wdata_q <= 64'h0;
          end
        end
        POLL: begin
          if (xfer_done_s) begin
            if (rdata_i[0]) begin
              state_q <= RD_HASH;
              cnt_q   <= 3'd0;
              req_q   <= 1'b1;
              addr_q  <= reg_addr(6'd18);
            end else begin
              poll_q <= (poll_q == PW'(TIMEOUT)) ? poll_q : poll_q + PW'(1);
              if (poll_last_s) begin
                state_q   <= FINISH;
                timeout_q <= 1'b1;
              end else if (POLL_GAP == 0) begin
                req_q <= 1'b1;
              end else begin
                state_q <= GAP;
                gap_q   <= '0;
              end
            end
          end
        end
        // The re-poll is issued on the last idle cycle so exactly POLL_GAP cycles stay quiet.
        GAP: begin
          if (gap_q == GW'(POLL_GAP - 1)) begin
            state_q <= POLL;
            req_q   <= 1'b1;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        RD_HASH: begin
          if (xfer_done_s) begin
            hash_q[{cnt_q[1:0], 6'd0} +: 64] <= rdata_i;
            if (cnt_q == 3'd3) begin
              state_q <= FINISH;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q  <= cnt_q + 3'd1;
              req_q  <= 1'b1;
              addr_q <= reg_addr(6'd19 + {3'd0, cnt_q});
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          match_q <= (hash_q == exp_q) && !timeout_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign match_o   = match_q;
  assign timeout_o = timeout_q;
  assign hash_o    = hash_q;
  assign req_o     = req_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;

endmodule

// File: tb/tb_hmac_job_master.sv
// Scoreboard bench for hmac_job_master: a bus model logs each granted transaction
// and each done pulse against queues filled when the job is launched.
module tb_hmac_job_master;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [511:0] key_i = 512'd0;
  logic [511:0] msg_i = 512'd0;
  logic [255:0] expected_i = 256'd0;
  logic         busy_o, done_o, match_o, timeout_o;
  logic [255:0] hash_o;
  logic         req_o, we_o;
  logic [63:0]  addr_o, wdata_o;
  logic         gnt_i = 1'b0;
  logic         rvalid_i = 1'b0;
  logic [63:0]  rdata_i = 64'd0;

  hmac_job_master #(.ADDR_WIDTH(64), .BASE_ADDR(64'h0), .POLL_GAP(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .key_i(key_i), .msg_i(msg_i),
    .expected_i(expected_i), .busy_o(busy_o), .done_o(done_o), .match_o(match_o),
    .timeout_o(timeout_o), .hash_o(hash_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} txn_t;
  typedef struct {logic match; logic tmo; logic [255:0] hash; int lat;} res_t;
  txn_t exp_txn[$];
  res_t exp_res[$];
  txn_t t;
  res_t r;

  int total = 0, bad = 0, cyc = 0;
  int gnt_dly = 0, rv_dly = 0, valid_on = 1;
  logic [255:0] model_hash = 256'd0;
  int req_age = 0, rd_age = 0, poll_n = 0, last_poll = -1, start_cyc = 0, done_seen = 0;
  bit rd_pend = 0, holding = 0;
  logic [63:0] rd_addr, hold_addr, hold_wdata;
  logic hold_we;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_val(input logic [63:0] a);
    int idx;
    if (a == 64'h88) return (valid_on != 0 && poll_n >= valid_on) ? 64'h1 : 64'h0;
    if (a >= 64'h90 && a <= 64'hA8) begin
      idx = int'((a - 64'h90) >> 3);
      return model_hash[idx*64 +: 64];
    end
    return 64'h0;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus model and transaction monitor: drives gnt/rvalid on the falling edge.
  always @(negedge clk_i) begin
    gnt_i = 1'b0;
    rvalid_i = 1'b0;
    if (rst_i) begin
      req_age = 0; rd_pend = 0; holding = 0;
    end else if (rd_pend) begin
      if (rd_age >= rv_dly) begin
        rvalid_i = 1'b1; rdata_i = rd_val(rd_addr); rd_pend = 0;
      end else rd_age++;
    end else if (req_o) begin
      if (holding) begin
        check("hold_we", we_o, hold_we);
        check("hold_addr", addr_o, hold_addr);
        check("hold_wdata", wdata_o, hold_wdata);
      end
      holding = 1; hold_we = we_o; hold_addr = addr_o; hold_wdata = wdata_o;
      if (req_age >= gnt_dly) begin
        gnt_i = 1'b1; req_age = 0; holding = 0;
        if (exp_txn.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_txn: got addr %0h want none", addr_o);
        end else begin
          t = exp_txn.pop_front();
          check("txn_we", we_o, t.we);
          check("txn_addr", addr_o, t.addr);
          if (t.we) check("txn_wdata", wdata_o, t.wdata);
        end
        if (!we_o && addr_o == 64'h88) begin
          poll_n++;
          if (gnt_dly == 0 && rv_dly == 0 && last_poll >= 0) check("poll_gap", cyc - last_poll, 5);
          last_poll = cyc;
        end
        if (!we_o) begin
          if (rv_dly == 0) begin
            rvalid_i = 1'b1; rdata_i = rd_val(addr_o);
          end else begin
            rd_pend = 1; rd_age = 1; rd_addr = addr_o;
          end
        end
      end else req_age++;
    end
  end

  // Completion monitor.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      done_seen++;
      if (exp_res.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_done: got done want none");
      end else begin
        r = exp_res.pop_front();
        check("match", match_o, r.match);
        check("timeout", timeout_o, r.tmo);
        check("hash", hash_o, r.hash);
        check("busy_at_done", busy_o, 1'b0);
        if (r.lat > 0) check("latency", cyc - start_cyc, r.lat);
      end
    end
  end

  task automatic push_job(input logic [511:0] k, input logic [511:0] m, input int npoll, input bit ok);
    for (int i = 0; i < 8; i++) exp_txn.push_back('{1'b1, 64'h110 + 64'(8*i), k[i*64 +: 64]});
    for (int i = 0; i < 8; i++) exp_txn.push_back('{1'b1, 64'h8 + 64'(8*i), m[i*64 +: 64]});
    exp_txn.push_back('{1'b1, 64'h0, 64'h1});
    exp_txn.push_back('{1'b1, 64'h0, 64'h0});
    for (int p = 0; p < npoll; p++) exp_txn.push_back('{1'b0, 64'h88, 64'h0});
    if (ok) for (int j = 0; j < 4; j++) exp_txn.push_back('{1'b0, 64'h90 + 64'(8*j), 64'h0});
  endtask

  task automatic launch(input logic [511:0] k, input logic [511:0] m, input logic [255:0] e,
                        input logic [255:0] h, input int vo, input int npoll, input bit ok,
                        input bit exp_match, input int lat);
    key_i = k; msg_i = m; expected_i = e; model_hash = h; valid_on = vo;
    poll_n = 0; last_poll = -1;
    push_job(k, m, npoll, ok);
    exp_res.push_back('{exp_match, !ok, ok ? h : 256'd0, lat});
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_job(input int d0, input bit poke);
    bit seen = 0;
    if (poke) begin
      repeat (10) @(negedge clk_i);
      key_i = {16{32'hBAD0BAD0}};
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk_i);
      if (done_seen > d0) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_wait: got no done want done");
    end
    repeat (3) @(negedge clk_i);
    check("missing_txn", exp_txn.size(), 0);
  endtask

  localparam logic [255:0] HA5 = {32{8'hA5}};
  localparam logic [255:0] HC = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  int d0;
  bit hit;

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req", req_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_hash", hash_o, 256'd0);
    check("rst_match", match_o, 1'b0);
    check("rst_tmo", timeout_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // zero-wait, digest matches, 25-cycle latency
    d0 = done_seen;
    launch({64{8'h0B}}, 512'h1, HA5, HA5, 1, 1, 1'b1, 1'b1, 25);
    check("busy_after_start", busy_o, 1'b1);
    finish_job(d0, 1'b0);

    // expected digest differs in bit 0
    d0 = done_seen;
    launch({64{8'h0B}}, 512'h1, HA5 ^ 256'h1, HA5, 1, 1, 1'b1, 1'b0, 25);
    finish_job(d0, 1'b0);

    // valid flag on third poll
    d0 = done_seen;
    launch({16{32'h01020304}}, {16{32'h0A0B0C0D}}, HC, HC, 3, 3, 1'b1, 1'b1, 0);
    finish_job(d0, 1'b0);

    // valid flag never set: timeout after 8 polls
    d0 = done_seen;
    launch({64{8'h0B}}, 512'h1, 256'd0, HA5, 0, 8, 1'b0, 1'b0, 0);
    finish_job(d0, 1'b0);

    // slow grant / slow rvalid, start pulsed while busy
    gnt_dly = 3; rv_dly = 2;
    d0 = done_seen;
    launch({16{32'hDEADBEEF}}, {16{32'h12345678}}, HC, HC, 2, 2, 1'b1, 1'b1, 0);
    finish_job(d0, 1'b1);

    // reset during fifth key write
    rv_dly = 0;
    launch({64{8'h0B}}, 512'h1, HA5, HA5, 1, 1, 1'b1, 1'b1, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk_i);
      if (req_o && addr_o == 64'h130) hit = 1;
    end
    check("reached_5th_write", hit, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_req", req_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    exp_txn.delete();
    exp_res.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("post_rst_hash", hash_o, 256'd0);
    gnt_dly = 0;
    d0 = done_seen;
    launch({64{8'h0B}}, 512'h1, HA5, HA5, 1, 1, 1'b1, 1'b1, 25);
    finish_job(d0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
